// File: rtl/arm_ctrl_pkg.sv
// Shared types and encodings for the ARM-subset multi-cycle controller:
// state enum, ALU codes, datapath select encodings and decode patterns.
package arm_ctrl_pkg;

  typedef enum logic [4:0] {
    S_IDLE   = 5'd0,
    S_FETCH  = 5'd1,
    S_DECODE = 5'd2,
    S_EXEC   = 5'd3,
    S_WB     = 5'd4,
    S_BX     = 5'd5,
    S_BADDR  = 5'd6,
    S_BPC    = 5'd7,
    S_BLINK  = 5'd8,
    S_BLADDR = 5'd9,
    S_MADDR  = 5'd10,
    S_MACC   = 5'd11,
    S_LDWB   = 5'd12,
    S_FAULT  = 5'd13
  } state_t;

  localparam logic [3:0] ALU_ADD_OP   = 4'b0100;
  localparam logic [3:0] ALU_SUB_OP   = 4'b0010;
  localparam logic [3:0] ALU_PASSA_OP = 4'b1000;

  localparam logic [1:0] PC_SEL_INC = 2'd0;
  localparam logic [1:0] PC_SEL_B   = 2'd1;
  localparam logic [1:0] PC_SEL_F   = 2'd2;

  localparam logic [1:0] RD_SEL_IR = 2'd0;
  localparam logic [1:0] RD_SEL_LR = 2'd1;
  localparam logic [1:0] RD_SEL_LD = 2'd2;

  localparam logic WD_SEL_F   = 1'b0;
  localparam logic WD_SEL_MEM = 1'b1;

  localparam logic [23:0] BX_PAT  = 24'h12FFF1;
  localparam logic [3:0]  B_PAT   = 4'b1010;
  localparam logic [3:0]  BL_PAT  = 4'b1011;
  localparam logic [1:0]  MEM_PAT = 2'b01;

endpackage

// File: rtl/arm_mc_ctrl_mem_wait_timer.sv
// Wait-state counter for memory handshakes: saturating 8-bit count of
// cycles without ack; an ack in the limit cycle takes priority over timeout.
module mem_wait_timer #(
  parameter int unsigned TMO_CYC = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic ack,
  output logic done,
  output logic timeout
);

  localparam logic [7:0] TMO = 8'(TMO_CYC);

  logic [7:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 8'd0;
    end else if (clr) begin
      count <= 8'd0;
    end else if (en && !ack && (count != 8'hFF)) begin
      count <= count + 8'd1;
    end
  end

  assign done    = en && ack;
  assign timeout = en && !ack && (count == TMO);

endmodule

// File: rtl/arm_mc_ctrl.sv
// Multi-cycle control FSM for the ARM-subset datapath: handshaked fetch,
// load/store, branches, condition-code skip and a sticky wait-state fault.
module arm_mc_ctrl
  import arm_ctrl_pkg::*;
#(
  parameter int unsigned ALU_OP_W   = 4,
  parameter int unsigned SHIFT_OP_W = 3,
  parameter int unsigned TMO_CYC    = 15,
  parameter logic [ALU_OP_W-1:0] ALU_ADD   = ALU_OP_W'(ALU_ADD_OP),
  parameter logic [ALU_OP_W-1:0] ALU_SUB   = ALU_OP_W'(ALU_SUB_OP),
  parameter logic [ALU_OP_W-1:0] ALU_PASSA = ALU_OP_W'(ALU_PASSA_OP)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           ir,
  input  logic                  imem_ack,
  input  logic                  dmem_ack,
  input  logic                  cond_pass,
  input  logic                  rm_imm_s,
  input  logic [1:0]            rs_imm_s,
  input  logic [SHIFT_OP_W-1:0] shift_op,
  input  logic [ALU_OP_W-1:0]   alu_op,
  input  logic                  s_bit,
  output logic                  imem_req,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic                  write_pc,
  output logic                  write_ir,
  output logic                  write_reg,
  output logic                  la,
  output logic                  lb,
  output logic                  lc,
  output logic                  lf,
  output logic [1:0]            pc_s,
  output logic                  alu_a_s,
  output logic                  alu_b_s,
  output logic [1:0]            rd_s,
  output logic                  wd_s,
  output logic                  s_ctrl,
  output logic                  rm_imm_s_ctrl,
  output logic [1:0]            rs_imm_s_ctrl,
  output logic [SHIFT_OP_W-1:0] shift_op_ctrl,
  output logic [ALU_OP_W-1:0]   alu_op_ctrl,
  output logic                  fault,
  output logic [4:0]            state_o
);

  state_t state, next_state;
  logic   is_bx, is_b, is_bl, is_mem, is_load, is_up;
  logic   wt_en, wt_ack, wt_clr, wt_done, wt_timeout;
  logic   unused_ir;

  assign is_bx   = (ir[27:4] == BX_PAT);
  assign is_b    = (ir[27:24] == B_PAT);
  assign is_bl   = (ir[27:24] == BL_PAT);
  assign is_mem  = (ir[27:26] == MEM_PAT);
  assign is_load = ir[20];
  assign is_up   = ir[23];
  assign unused_ir = ^{ir[31:28], ir[3:0]};

  // The timer only observes the ack that belongs to the current wait state.
  assign wt_en  = (state == S_FETCH) || (state == S_MACC);
  assign wt_ack = (state == S_FETCH) ? imem_ack : dmem_ack;
  assign wt_clr = ((next_state == S_FETCH) || (next_state == S_MACC)) && (next_state != state);

  mem_wait_timer #(.TMO_CYC(TMO_CYC)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (wt_clr),
    .en      (wt_en),
    .ack     (wt_ack),
    .done    (wt_done),
    .timeout (wt_timeout)
  );

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   next_state = S_FETCH;
      S_FETCH: begin
        if (wt_done)         next_state = S_DECODE;
        else if (wt_timeout) next_state = S_FAULT;
        else                 next_state = S_FETCH;
      end
      S_DECODE: begin
        if (!cond_pass)   next_state = S_FETCH;
        else if (is_bx)   next_state = S_BX;
        else if (is_b)    next_state = S_BADDR;
        else if (is_bl)   next_state = S_BLINK;
        else if (is_mem)  next_state = S_MADDR;
        else              next_state = S_EXEC;
      end
      // Compare/test opcodes (ir[24:23]==10) only update flags.
      S_EXEC:   next_state = (ir[24:23] != 2'b10) ? S_WB : S_FETCH;
      S_WB:     next_state = S_FETCH;
      S_BX:     next_state = S_FETCH;
      S_BADDR:  next_state = S_BPC;
      S_BPC:    next_state = S_FETCH;
      S_BLINK:  next_state = S_BLADDR;
      S_BLADDR: next_state = S_BPC;
      S_MADDR:  next_state = S_MACC;
      S_MACC: begin
        if (wt_done)         next_state = is_load ? S_LDWB : S_FETCH;
        else if (wt_timeout) next_state = S_FAULT;
        else                 next_state = S_MACC;
      end
      S_LDWB:   next_state = S_FETCH;
      S_FAULT:  next_state = S_FAULT;
      default:  next_state = S_FAULT;
    endcase
  end

  // Outputs are registered from next_state so they are stable for the whole state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      imem_req      <= 1'b0;
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      write_pc      <= 1'b0;
      write_ir      <= 1'b0;
      write_reg     <= 1'b0;
      la            <= 1'b0;
      lb            <= 1'b0;
      lc            <= 1'b0;
      lf            <= 1'b0;
      fault         <= 1'b0;
      pc_s          <= 2'd0;
      alu_a_s       <= 1'b0;
      alu_b_s       <= 1'b0;
      rd_s          <= 2'd0;
      wd_s          <= 1'b0;
      s_ctrl        <= 1'b0;
      rm_imm_s_ctrl <= 1'b0;
      rs_imm_s_ctrl <= 2'd0;
      shift_op_ctrl <= '0;
      alu_op_ctrl   <= '0;
    end else begin
      state     <= next_state;
      imem_req  <= 1'b0;
      dmem_req  <= 1'b0;
      dmem_we   <= 1'b0;
      write_pc  <= 1'b0;
      write_ir  <= 1'b0;
      write_reg <= 1'b0;
      la        <= 1'b0;
      lb        <= 1'b0;
      lc        <= 1'b0;
      lf        <= 1'b0;
      fault     <= 1'b0;
      case (next_state)
        S_FETCH: imem_req <= 1'b1;
        S_DECODE: begin
          write_ir <= 1'b1;
          write_pc <= 1'b1;
          pc_s     <= PC_SEL_INC;
          la       <= 1'b1;
          lb       <= 1'b1;
          lc       <= 1'b1;
        end
        S_EXEC: begin
          lf            <= 1'b1;
          s_ctrl        <= s_bit;
          rm_imm_s_ctrl <= rm_imm_s;
          rs_imm_s_ctrl <= rs_imm_s;
          shift_op_ctrl <= shift_op;
          alu_op_ctrl   <= alu_op;
        end
        S_WB: begin
          write_reg <= 1'b1;
          rd_s      <= RD_SEL_IR;
          wd_s      <= WD_SEL_F;
        end
        S_BX: begin
          write_pc <= 1'b1;
          pc_s     <= PC_SEL_B;
        end
        S_BADDR: begin
          alu_a_s     <= 1'b1;
          alu_b_s     <= 1'b1;
          alu_op_ctrl <= ALU_ADD;
          s_ctrl      <= 1'b0;
          lf          <= 1'b1;
        end
        S_BPC: begin
          write_pc <= 1'b1;
          pc_s     <= PC_SEL_F;
          alu_a_s  <= 1'b0;
          alu_b_s  <= 1'b0;
          rd_s     <= RD_SEL_IR;
        end
        S_BLINK: begin
          alu_a_s     <= 1'b1;
          alu_op_ctrl <= ALU_PASSA;
          lf          <= 1'b1;
        end
        // Link register takes the old F while F latches the branch target.
        S_BLADDR: begin
          write_reg   <= 1'b1;
          rd_s        <= RD_SEL_LR;
          wd_s        <= WD_SEL_F;
          alu_a_s     <= 1'b1;
          alu_b_s     <= 1'b1;
          alu_op_ctrl <= ALU_ADD;
          s_ctrl      <= 1'b0;
          lf          <= 1'b1;
        end
        S_MADDR: begin
          alu_b_s     <= ~ir[25];
          alu_op_ctrl <= is_up ? ALU_ADD : ALU_SUB;
          s_ctrl      <= 1'b0;
          lf          <= 1'b1;
        end
        S_MACC: begin
          dmem_req <= 1'b1;
          dmem_we  <= ~is_load;
        end
        S_LDWB: begin
          write_reg <= 1'b1;
          rd_s      <= RD_SEL_LD;
          wd_s      <= WD_SEL_MEM;
        end
        S_FAULT: fault <= 1'b1;
        default: begin
        end
      endcase
    end
  end

  assign state_o = state;

endmodule

// File: doc/arm_mc_ctrl.md
Name: arm_mc_ctrl

Overview:
- Parametrised multi-cycle control FSM for the ARM-subset datapath (register file, A/B/C latches, barrel shifter, ALU with F/flag latches, PC/IR).
- Supersedes the fixed single-cycle-fetch controller: adds handshaked instruction/data memory, LDR/STR, condition-code skip, wait-state timeout with sticky fault, and parametrised control-field widths.

Parameters:
- ALU_OP_W, 4, width of ALU operation code
- SHIFT_OP_W, 3, width of shifter operation code
- TMO_CYC, 15, max wait cycles for imem_ack/dmem_ack before fault (1..255)
- ALU_ADD, 4'b0100, ALU code for add
- ALU_SUB, 4'b0010, ALU code for subtract
- ALU_PASSA, 4'b1000, ALU code passing A to F

Ports:
- clk  in  1  clock
- rst  in  1  reset
- ir  in  32  current instruction register
- imem_ack  in  1  instruction word valid
- dmem_ack  in  1  data access complete
- cond_pass  in  1  condition field satisfied by current flags
- rm_imm_s, rs_imm_s, shift_op, alu_op, s_bit  in  1/2/SHIFT_OP_W/ALU_OP_W/1  decoder fields
- imem_req  out  1  instruction fetch request
- dmem_req, dmem_we  out  1,1  data request, write strobe
- write_pc, write_ir, write_reg  out  1 each  register enables
- la, lb, lc, lf  out  1 each  latch enables
- pc_s  out  2  0=PC+4, 1=B latch, 2=F
- alu_a_s, alu_b_s  out  1,1  A: 0=reg, 1=PC; B: 0=shifter, 1=ext immediate
- rd_s  out  2  0=ir rd, 1=R14, 2=ir rd (load)
- wd_s  out  1  write data: 0=F, 1=dmem rdata
- s_ctrl, rm_imm_s_ctrl, rs_imm_s_ctrl, shift_op_ctrl, alu_op_ctrl  out  as inputs  registered datapath controls
- fault  out  1  sticky timeout fault
- state_o  out  5  current state (debug)

Behaviour:
- Reset: rst is asynchronous and active-high; the clock is clk. On reset, state goes to IDLE and every output is 0.
- Output timing: all outputs are registered on posedge from next_state, so they are valid for the whole state. Outputs not listed for a state are 0. Select signals (pc_s, alu_*_s, rd_s, wd_s, *_ctrl) hold their value unless a state sets them.
- Decode flags:
  - isBX: ir[27:4]==24'h12FFF1
  - isB: ir[27:24]==1010
  - isBL: ir[27:24]==1011
  - isMEM: ir[27:26]==01, L=ir[20], U=ir[23]
- States:
  - IDLE: goes to FETCH next cycle.
  - FETCH: imem_req=1, wait counter runs. On imem_ack: write_ir=1, write_pc=1, pc_s=0, go to DECODE. On count==TMO_CYC: go to FAULT.
  - DECODE: la=lb=lc=1.
    - !cond_pass: go to FETCH (skip; no writes).
    - Otherwise: isBX->BX, isB->BADDR, isBL->BLINK, isMEM->MADDR, else EXEC.
  - EXEC: lf=1; latch rm_imm_s, rs_imm_s, shift_op, alu_op, s_bit into *_ctrl. Go to WB if ir[24:23]!=10 (not a compare/test), else FETCH.
  - WB: write_reg=1, rd_s=0, wd_s=0, then FETCH.
  - BX: write_pc=1, pc_s=1, then FETCH.
  - BADDR: alu_a_s=1, alu_b_s=1, alu_op_ctrl=ALU_ADD, s_ctrl=0, lf=1, then BPC.
  - BPC: write_pc=1, pc_s=2; restore alu_a_s=alu_b_s=0, rd_s=0. Then FETCH.
  - BLINK: alu_a_s=1, alu_op_ctrl=ALU_PASSA, lf=1, then BLADDR.
  - BLADDR: write_reg=1, rd_s=1, wd_s=0. Same ALU controls as BADDR. Then BPC.
  - MADDR: alu_b_s=~ir[25], alu_op_ctrl= U ? ALU_ADD : ALU_SUB, s_ctrl=0, lf=1, then MACC.
  - MACC: dmem_req=1, dmem_we=~L, wait counter runs. On dmem_ack: L ? LDWB : FETCH. On timeout: FAULT.
  - LDWB: write_reg=1, rd_s=2, wd_s=1, then FETCH.
  - FAULT: fault=1, all enables 0. Absorbing until rst.
- Wait counter:
  - 8-bit, cleared on entry to FETCH/MACC.
  - Increments each cycle the ack is low. Saturates; no wrap.
  - Ack in the same cycle that count reaches TMO_CYC: the ack wins.
- Spurious acks: imem_ack outside FETCH and dmem_ack outside MACC are ignored.
- Reset mid-access: requests drop asynchronously; no write enable is issued.

Decomposition:
- Shared package arm_ctrl_pkg holds:
  - state enum, 5-bit
  - ALU op constants
  - pc_s, rd_s, wd_s encodings
  - decode-pattern constants (BX, B, BL, MEM)
- Natural sub-module: mem_wait_timer. Counter with clear/enable/ack inputs; outputs done and timeout.

Test Plan:
- ADD R1,R2,R3 (E0821003), imem_ack after 2 waits -> FETCH(3 cyc), DECODE, EXEC with alu_op_ctrl=0100 and lf=1, WB with write_reg=1 and rd_s=0, back to FETCH.
- BL (EB000004), 0 waits -> BLINK (ALU_PASSA), BLADDR (write_reg=1, rd_s=1), BPC (write_pc=1, pc_s=2); alu_a_s returns to 0 afterward.
- LDR R0,[R1,#4] (E5910004), dmem_ack after 3 cycles -> MADDR (alu_op=0100, alu_b_s=1), MACC (dmem_req=1, dmem_we=0) for 4 cycles, LDWB (wd_s=1, rd_s=2).
- STR with U=0 (E5010004) -> alu_op_ctrl=0010, dmem_we=1, no LDWB, returns to FETCH.
- cond_pass=0 on ADD -> DECODE then FETCH; write_reg never asserted.
- imem_ack held low 16 cycles with TMO_CYC=15 -> FAULT, fault=1 stays set; rst asserted mid-FAULT -> all outputs 0 immediately, IDLE.
